// File: rtl/lbist_pkg.sv
// lbist_pkg: LBIST state encodings and counter-width helpers shared across the LBIST path
package lbist_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        SHIFT   = 3'd1,
        CAPTURE = 3'd2,
        UNLOAD  = 3'd3,
        DONE    = 3'd4
    } lbist_state_t;

    localparam int STATE_W = 3;

    function automatic int cnt_w(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/lbist_counter.sv
// lbist_counter: up-counter with sync clear/enable; tc flags the last count before MAX
module lbist_counter #(
    parameter int WIDTH = 4,
    parameter int MAX   = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             en,
    output logic [WIDTH-1:0] cnt,
    output logic             tc
);

    always_ff @(posedge clk)
        if (rst || clr) cnt <= '0;
        else if (en) cnt <= cnt + WIDTH'(1);

    assign tc = cnt == WIDTH'(MAX - 1);

endmodule

// File: rtl/lbist_scan_loader.sv
// lbist_scan_loader: sequences LFSR-driven scan shift/capture/unload and gates the MISR
module lbist_scan_loader
    import lbist_pkg::*;
#(
    parameter int N_LFSR     = 20,
    parameter int N_CHAINS   = 16,
    parameter int SCAN_LEN   = 64,
    parameter int N_PATTERNS = 1024
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             start,
    input  logic [N_LFSR-1:0]                lfsr_dout,
    output logic                             lfsr_en,
    output logic                             scan_en,
    output logic [N_CHAINS-1:0]              scan_in,
    output logic                             capture,
    output logic                             misr_en,
    output logic                             busy,
    output logic                             done,
    output logic [$clog2(N_PATTERNS+1)-1:0]  pattern_cnt
);

    localparam int SW = cnt_w(SCAN_LEN);
    localparam int PW = $clog2(N_PATTERNS + 1);

    lbist_state_t  state;
    logic          first_pass;
    logic          shift_tc;
    logic          pat_tc;
    logic [SW-1:0] shift_cnt;
    logic          shifting;

    assign shifting = state == SHIFT || state == UNLOAD;

    lbist_counter #(.WIDTH(SW), .MAX(SCAN_LEN)) u_shift_cnt (
        .clk (clk),
        .rst (rst),
        .clr (!shifting || shift_tc),
        .en  (shifting),
        .cnt (shift_cnt),
        .tc  (shift_tc)
    );

    // pat_tc is seen during CAPTURE, i.e. the increment about to happen reaches N_PATTERNS
    lbist_counter #(.WIDTH(PW), .MAX(N_PATTERNS)) u_pattern_cnt (
        .clk (clk),
        .rst (rst),
        .clr (state == IDLE && start),
        .en  (state == CAPTURE),
        .cnt (pattern_cnt),
        .tc  (pat_tc)
    );

    always_ff @(posedge clk)
        if (rst) begin
            state      <= IDLE;
            first_pass <= 1'b1;
        end else begin
            case (state)
                IDLE: if (start) begin
                    state      <= SHIFT;
                    first_pass <= 1'b1;
                end
                SHIFT:   if (shift_tc) state <= CAPTURE;
                CAPTURE: begin
                    state      <= pat_tc ? UNLOAD : SHIFT;
                    first_pass <= 1'b0;
                end
                UNLOAD:  if (shift_tc) state <= DONE;
                DONE:    if (!start) state <= IDLE;
                default: state <= IDLE;
            endcase
        end

    // the first load pushes out no valid response, so the MISR is held off for it
    assign lfsr_en = state == SHIFT;
    assign scan_en = shifting;
    assign capture = state == CAPTURE;
    assign misr_en = (state == SHIFT && !first_pass) || state == UNLOAD;
    assign busy    = state == SHIFT || state == CAPTURE || state == UNLOAD;
    assign done    = state == DONE;
    assign scan_in = state == SHIFT ? lfsr_dout[N_CHAINS-1:0] : '0;

endmodule
